fft8_frame_ctrl: RTL and testbench

Frame sequencer for the 8-point pipelined FFT core. It collects N serial complex samples from a valid/ready stream and presents them to the core's parallel inputs in bit-reversed slot order. It waits out the core's fixed pipeline latency, captures the parallel result, and streams it out serially in natural order with valid/ready and a last flag. One frame is in flight at a time.

---
 rtl/fft8_frame_ctrl.sv | 147 ++++++++++++++
 tb/tb_fft8_frame_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for the 8-point pipelined FFT core: serial in (bit-reversed
// slots), fixed-latency wait, parallel capture, serial natural-order out.
module fft8_frame_ctrl #(
    parameter int N       = 8,
    parameter int W       = 16,
    parameter int LATENCY = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_re,
    input  logic [W-1:0] s_im,
    output logic [W-1:0] fft_x_re [N],
    output logic [W-1:0] fft_x_im [N],
    input  logic [W-1:0] fft_y_re [N],
    input  logic [W-1:0] fft_y_im [N],
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_re,
    output logic [W-1:0] m_im,
    output logic         m_last,
    output logic         busy,
    output logic [15:0]  frame_count
);

    localparam int LOG2N = $clog2(N);
    localparam int WCW   = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_WAIT,
        ST_UNLOAD
    } state_e;

    state_e           state_q, state_d;
    logic [LOG2N-1:0] in_cnt_q, in_cnt_d;
    logic [LOG2N-1:0] out_cnt_q, out_cnt_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic [W-1:0]     in_re_q [N];
    logic [W-1:0]     in_re_d [N];
    logic [W-1:0]     in_im_q [N];
    logic [W-1:0]     in_im_d [N];
    logic [W-1:0]     out_re_q [N];
    logic [W-1:0]     out_re_d [N];
    logic [W-1:0]     out_im_q [N];
    logic [W-1:0]     out_im_d [N];

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    // rst_n gates s_ready so no sample is offered-and-lost during reset
    assign s_ready     = rst_n && (state_q == ST_LOAD);
    assign m_valid     = (state_q == ST_UNLOAD);
    assign m_last      = (state_q == ST_UNLOAD) && (out_cnt_q == LAST_IDX);
    assign busy        = (state_q != ST_LOAD);
    assign m_re        = out_re_q[out_cnt_q];
    assign m_im        = out_im_q[out_cnt_q];
    assign frame_count = frame_count_q;
    assign fft_x_re    = in_re_q;
    assign fft_x_im    = in_im_q;

    always_comb begin
        state_d       = state_q;
        in_cnt_d      = in_cnt_q;
        out_cnt_d     = out_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        frame_count_d = frame_count_q;
        in_re_d       = in_re_q;
        in_im_d       = in_im_q;
        out_re_d      = out_re_q;
        out_im_d      = out_im_q;

        unique case (state_q)
            ST_LOAD: begin
                if (s_valid && s_ready) begin
                    in_re_d[bitrev(in_cnt_q)] = s_re;
                    in_im_d[bitrev(in_cnt_q)] = s_im;
                    if (in_cnt_q == LAST_IDX) begin
                        in_cnt_d   = '0;
                        wait_cnt_d = WCW'(LATENCY);
                        state_d    = ST_WAIT;
                    end else begin
                        in_cnt_d = in_cnt_q + LOG2N'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - WCW'(1);
                end else begin
                    for (int i = 0; i < N; i++) begin
                        out_re_d[i] = fft_y_re[i];
                        out_im_d[i] = fft_y_im[i];
                    end
                    state_d = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (m_ready) begin
                    if (out_cnt_q == LAST_IDX) begin
                        out_cnt_d     = '0;
                        frame_count_d = frame_count_q + 16'd1;
                        state_d       = ST_LOAD;
                    end else begin
                        out_cnt_d = out_cnt_q + LOG2N'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_LOAD;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            frame_count_q <= '0;
            in_re_q       <= '{default: '0};
            in_im_q       <= '{default: '0};
            out_re_q      <= '{default: '0};
            out_im_q      <= '{default: '0};
        end else begin
            state_q       <= state_d;
            in_cnt_q      <= in_cnt_d;
            out_cnt_q     <= out_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            frame_count_q <= frame_count_d;
            in_re_q       <= in_re_d;
            in_im_q       <= in_im_d;
            out_re_q      <= out_re_d;
            out_im_q      <= out_im_d;
        end
    end

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Directed + randomized bench for fft8_frame_ctrl with a stub 3-stage core
// and a frame-level reference model (slot = bitrev(sample), bins in order).
module tb_fft8_frame_ctrl;

    localparam int N   = 8;
    localparam int W   = 16;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_re, s_im;
    logic [W-1:0] fft_x_re [N];
    logic [W-1:0] fft_x_im [N];
    logic [W-1:0] fft_y_re [N];
    logic [W-1:0] fft_y_im [N];
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_re, m_im;
    logic         m_last;
    logic         busy;
    logic [15:0]  frame_count;

    int vectors     = 0;
    int miscompares = 0;

    bit           const_mode;
    logic [15:0]  exp_fc;
    logic [W-1:0] f_re [N];
    logic [W-1:0] f_im [N];
    logic [W-1:0] e_re [N];
    logic [W-1:0] e_im [N];
    logic [W-1:0] p1_re [N], p1_im [N];
    logic [W-1:0] p2_re [N], p2_im [N];
    logic [W-1:0] p3_re [N], p3_im [N];

    always #5 clk = ~clk;

    fft8_frame_ctrl #(.N(N), .W(W), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_re       (s_re),
        .s_im       (s_im),
        .fft_x_re   (fft_x_re),
        .fft_x_im   (fft_x_im),
        .fft_y_re   (fft_y_re),
        .fft_y_im   (fft_y_im),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_re       (m_re),
        .m_im       (m_im),
        .m_last     (m_last),
        .busy       (busy),
        .frame_count(frame_count)
    );

    // Stub core: three register stages, then a fixed per-bin transform
    always @(posedge clk) begin
        p1_re <= fft_x_re;
        p1_im <= fft_x_im;
        p2_re <= p1_re;
        p2_im <= p1_im;
        p3_re <= p2_re;
        p3_im <= p2_im;
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (const_mode) begin
                fft_y_re[i] = 16'h1000 + 16'(i);
                fft_y_im[i] = 16'h2000 + 16'(i);
            end else begin
                fft_y_re[i] = p3_re[i] + 16'(i * 257);
                fft_y_im[i] = ~p3_im[i];
            end
        end
    end

    function automatic int rev3(input int i);
        return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic make_frame(input bit counting);
        for (int k = 0; k < N; k++) begin
            f_re[k] = counting ? 16'(k) : 16'($urandom);
            f_im[k] = counting ? 16'h0100 + 16'(k) : 16'($urandom);
        end
        for (int i = 0; i < N; i++) begin
            if (const_mode) begin
                e_re[i] = 16'h1000 + 16'(i);
                e_im[i] = 16'h2000 + 16'(i);
            end else begin
                e_re[i] = f_re[rev3(i)] + 16'(i * 257);
                e_im[i] = ~f_im[rev3(i)];
            end
        end
    endtask

    // gap: 0 none, 1 pattern 1,0,0, 2 random; ends at negedge after last accept
    task automatic send_frame(input int gap, input bit hold_high);
        int  k;
        int  cyc;
        bit  v;
        bit  acc;
        k   = 0;
        cyc = 0;
        while (k < N && cyc < 200) begin
            unique case (gap)
                0: v = 1'b1;
                1: v = (cyc % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            s_valid = v;
            s_re    = f_re[k];
            s_im    = f_im[k];
            acc     = v && s_ready;
            @(posedge clk);
            if (acc) k++;
            @(negedge clk);
            cyc++;
        end
        s_valid = hold_high;
        s_re    = 16'hDEAD;
        s_im    = 16'hBEEF;
        chk("send_count", k, N);
        chk("s_ready_after_load", s_ready, 0);
        chk("busy_after_load", busy, 1);
    endtask

    task automatic check_latency();
        for (int j = 0; j < LAT; j++) begin
            chk("m_valid_early", m_valid, 0);
            @(negedge clk);
        end
        chk("m_valid_early", m_valid, 0);
        @(negedge clk);
        chk("m_valid_on_time", m_valid, 1);
    endtask

    // rmode: 0 always ready, 1 alternate, 2 random; stall_at opens a 5-cycle hold
    task automatic recv_frame(input int rmode, input int stall_at, input int nbins);
        int idx;
        int cyc;
        bit r;
        idx = 0;
        cyc = 0;
        while (idx < nbins && cyc < 300) begin
            unique case (rmode)
                0: r = 1'b1;
                1: r = (cyc % 2 == 1);
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5) r = 1'b0;
            m_ready = r;
            chk("m_valid_hold", m_valid, 1);
            chk("m_re", m_re, e_re[idx]);
            chk("m_im", m_im, e_im[idx]);
            chk("m_last", m_last, (idx == N - 1));
            chk("s_ready_unload", s_ready, 0);
            @(posedge clk);
            if (r) idx++;
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        chk("recv_count", idx, nbins);
        if (nbins == N) begin
            exp_fc = exp_fc + 16'd1;
            chk("s_ready_after_last", s_ready, 1);
            chk("m_valid_after_last", m_valid, 0);
            chk("busy_after_last", busy, 0);
            chk("frame_count", frame_count, exp_fc);
        end
    endtask

    task automatic full_frame(input bit counting, input int gap, input bit hold,
                              input int rmode, input int stall_at);
        make_frame(counting);
        send_frame(gap, hold);
        check_latency();
        recv_frame(rmode, stall_at, N);
        s_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        s_re       = '0;
        s_im       = '0;
        m_ready    = 1'b0;
        const_mode = 1'b1;
        exp_fc     = '0;
        repeat (3) @(negedge clk);
        s_valid = 1'b1;
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_x_re0", fft_x_re[0], 0);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s_ready_idle", s_ready, 1);

        // order check and constant-core capture
        make_frame(1'b1);
        send_frame(0, 1'b0);
        for (int j = 0; j < N; j++) begin
            chk("x_re_order", fft_x_re[j], rev3(j));
            chk("x_im_order", fft_x_im[j], 32'h0100 + rev3(j));
        end
        check_latency();
        recv_frame(0, -1, N);

        // backpressure with random data
        const_mode = 1'b0;
        full_frame(1'b0, 2, 1'b0, 1, 3);

        // input gaps, s_valid held high through WAIT/UNLOAD
        full_frame(1'b0, 1, 1'b1, 2, -1);
        full_frame(1'b0, 2, 1'b0, 2, 0);

        // reset mid-UNLOAD after bin 3
        make_frame(1'b0);
        send_frame(0, 1'b0);
        check_latency();
        recv_frame(0, -1, 4);
        chk("pre_reset_valid", m_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_m_valid", m_valid, 0);
        chk("async_s_ready", s_ready, 0);
        chk("async_busy", busy, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_fc = '0;
        #1;
        chk("post_reset_s_ready", s_ready, 1);
        chk("post_reset_fc", frame_count, 0);
        chk("post_reset_x", fft_x_re[3], 0);
        @(negedge clk);
        const_mode = 1'b1;
        full_frame(1'b1, 0, 1'b0, 0, -1);

        // back-to-back frames
        const_mode = 1'b0;
        for (int f = 0; f < 3; f++) begin
            full_frame(1'b0, 0, 1'b0, 0, -1);
        end

        // frame counter wrap
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        exp_fc = 16'hFFFF;
        #1;
        chk("fc_forced", frame_count, 16'hFFFF);
        @(negedge clk);
        full_frame(1'b0, 2, 1'b0, 2, -1);
        chk("fc_wrapped", frame_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
